// File: rtl/snax_reshuffler_job_scheduler.sv
// Job scheduler for the data reshuffler: queues CSR job descriptors in a FIFO,
// launches them one at a time, tracks output beats and reports status counters.
module snax_reshuffler_job_scheduler #(
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned QueueDepth   = 4,
    parameter int unsigned CntWidth     = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [RegDataWidth-1:0]       job_cfg_i,
    input  logic [CntWidth-1:0]           job_beats_i,
    input  logic                          job_valid_i,
    output logic                          job_ready_o,
    output logic [RegDataWidth-1:0]       acc_ctrl_o,
    output logic                          acc_ctrl_valid_o,
    input  logic                          acc_ctrl_ready_i,
    input  logic                          acc_busy_i,
    input  logic                          out_beat_i,
    output logic                          busy_o,
    output logic [$clog2(QueueDepth):0]   queue_level_o,
    output logic [CntWidth-1:0]           jobs_done_o,
    output logic [CntWidth-1:0]           perf_cycles_o,
    output logic                          err_o
);

    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] Depth = LvlW'(QueueDepth);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [RegDataWidth-1:0] cfg_mem   [QueueDepth];
    logic [CntWidth-1:0]     beats_mem [QueueDepth];
    logic [PtrW-1:0]         wr_ptr;
    logic [PtrW-1:0]         rd_ptr;
    logic [LvlW-1:0]         level;
    logic [CntWidth-1:0]     remaining;
    logic                    push;
    logic                    pop;

    // No bypass: readiness depends on the stored level only, never on a pop.
    assign job_ready_o   = (level < Depth);
    assign push          = job_valid_i & job_ready_o;
    assign pop           = (state == ISSUE) & acc_ctrl_ready_i;
    assign acc_ctrl_o    = cfg_mem[rd_ptr];
    assign queue_level_o = level;
    assign busy_o        = (state != IDLE) | (level != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < QueueDepth; i++) begin
                cfg_mem[i]   <= '0;
                beats_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                cfg_mem[wr_ptr]   <= job_cfg_i;
                beats_mem[wr_ptr] <= job_beats_i;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            acc_ctrl_valid_o <= 1'b0;
            remaining        <= '0;
            jobs_done_o      <= '0;
            err_o            <= 1'b0;
        end else begin
            if (out_beat_i && state != RUN) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        state            <= ISSUE;
                        acc_ctrl_valid_o <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (acc_ctrl_ready_i) begin
                        acc_ctrl_valid_o <= 1'b0;
                        remaining        <= beats_mem[rd_ptr];
                        state            <= (beats_mem[rd_ptr] == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (out_beat_i) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CntWidth'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!acc_busy_i) begin
                        jobs_done_o <= jobs_done_o + 1'b1;
                        // A push landing this very cycle counts as pending work.
                        if (level != '0 || push) begin
                            state            <= ISSUE;
                            acc_ctrl_valid_o <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    acc_ctrl_valid_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cycles_o <= '0;
        end else if (busy_o && perf_cycles_o != '1) begin
            perf_cycles_o <= perf_cycles_o + 1'b1;
        end
    end

endmodule
